// File: rtl/sprite_rom_arb_if.sv
// Bus bundle between the four sprite requesters, the arbiter and the sprite ROM.
// Carries the request/address inputs, grant and read-return outputs, plus the debug pointer.
interface sprite_rom_arb_if #(
   parameter int AW = 17,
   parameter int DW = 12
);
   // Handshake: req[k] is a level held, together with addr_k, until gnt[k] pulses for one
   // cycle. A requester may drop req or present a new address in its gnt cycle.
   // rd_valid[k] pulses exactly one cycle after gnt[k] and qualifies rd_data.
   logic [3:0]    req;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [AW-1:0] addr2;
   logic [AW-1:0] addr3;
   logic          freeze;
   logic [3:0]    gnt;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic [3:0]    rd_valid;
   logic [DW-1:0] rd_data;
   logic          busy;
   logic [1:0]    ptr;

   modport master (
      output req, addr0, addr1, addr2, addr3, freeze, rom_data,
      input  gnt, rom_addr, rd_valid, rd_data, busy, ptr
   );

   modport slave (
      input  req, addr0, addr1, addr2, addr3, freeze, rom_data,
      output gnt, rom_addr, rd_valid, rd_data, busy, ptr
   );
endinterface

// File: rtl/sprite_rom_arb.sv
// Four-way round-robin arbiter in front of a synchronous-read sprite ROM.
// One access per clock; read data is returned to the winner two cycles after the decision.
module sprite_rom_arb #(
   parameter int AW = 17,
   parameter int DW = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   sprite_rom_arb_if.slave bus
);

   logic [3:0]    gnt_q;
   logic [3:0]    gnt_d;
   logic [3:0]    rd_valid_q;
   logic [AW-1:0] rom_addr_q;
   logic [AW-1:0] rom_addr_d;
   logic [1:0]    ptr_q;
   logic [1:0]    ptr_d;

   logic          win_found;
   logic [1:0]    win_idx;
   logic [1:0]    cand;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] rd_data_w;

   // Search starts at the pointer and wraps; the first requester found wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      for (int i = 0; i < 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      win_addr = bus.addr0;
      case (win_idx)
         2'd0: win_addr = bus.addr0;
         2'd1: win_addr = bus.addr1;
         2'd2: win_addr = bus.addr2;
         2'd3: win_addr = bus.addr3;
      endcase
   end

   // Freeze or an idle cycle leaves the pointer and ROM address untouched.
   always_comb begin
      gnt_d      = 4'b0000;
      rom_addr_d = rom_addr_q;
      ptr_d      = ptr_q;
      if (win_found && !bus.freeze) begin
         gnt_d      = 4'b0001 << win_idx;
         rom_addr_d = win_addr;
         ptr_d      = win_idx + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q      <= 4'b0000;
         rd_valid_q <= 4'b0000;
         rom_addr_q <= '0;
         ptr_q      <= 2'd0;
      end else begin
         gnt_q      <= gnt_d;
         rd_valid_q <= gnt_q;
         rom_addr_q <= rom_addr_d;
         ptr_q      <= ptr_d;
      end
   end

   assign rd_data_w    = bus.rom_data;
   assign bus.rd_data  = rd_data_w;
   assign bus.gnt      = gnt_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.ptr      = ptr_q;
   assign bus.busy     = (|bus.req) | (|rd_valid_q);

endmodule

// File: tb/tb_sprite_rom_arb.sv
// Bench for sprite_rom_arb: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural round-robin model.
module tb_sprite_rom_arb;

   localparam int AW = 17;
   localparam int DW = 12;

   logic clk;
   logic rst_n;

   sprite_rom_arb_if #(.AW(AW), .DW(DW)) bus ();

   sprite_rom_arb #(.AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- stimulus variables ----------------
   logic [3:0]    r_in;
   logic [AW-1:0] a_in [4];
   logic          frz;
   logic [DW-1:0] rom_q;

   assign bus.req      = r_in;
   assign bus.addr0    = a_in[0];
   assign bus.addr1    = a_in[1];
   assign bus.addr2    = a_in[2];
   assign bus.addr3    = a_in[3];
   assign bus.freeze   = frz;
   assign bus.rom_data = rom_q;

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return a[11:0] ^ {a[16:12], 7'h35} ^ 12'h9c3;
   endfunction

   // Synchronous-read ROM: data for the sampled address appears one cycle later.
   always @(posedge clk) rom_q <= rom_f(bus.rom_addr);

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int            m_p;
   logic [3:0]    m_gnt;
   logic [3:0]    m_rdv;
   logic [AW-1:0] m_addr;
   logic [3:0]    s_req;
   logic          s_frz;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_p    = 0;
         m_gnt  = 4'b0000;
         m_rdv  = 4'b0000;
         m_addr = '0;
         s_req  = 4'b0000;
         s_frz  = 1'b0;
         exp_q.delete();
      end else begin
         bit found;
         int w;
         s_req = r_in;
         s_frz = frz;
         m_rdv = m_gnt;
         m_gnt = 4'b0000;
         found = 1'b0;
         w     = 0;
         if (!frz) begin
            for (int j = 0; j < 4; j++) begin
               if (!found && r_in[(m_p + j) % 4]) begin
                  found = 1'b1;
                  w     = (m_p + j) % 4;
               end
            end
         end
         if (found) begin
            m_gnt     = 4'b0000;
            m_gnt[w]  = 1'b1;
            m_addr    = a_in[w];
            m_p       = (w + 1) % 4;
            exp_q.push_back(rom_f(m_addr));
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int wt [4] = '{0, 0, 0, 0};

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) wt[k] = 0;
      end else begin
         int worst;
         check("gnt", bus.gnt, m_gnt);
         check("rd_valid", bus.rd_valid, m_rdv);
         check("rom_addr", bus.rom_addr, m_addr);
         check("busy", bus.busy, (|r_in) | (|m_rdv));
         check("gnt_onehot", $countones(bus.gnt) <= 1, 1);
         if (bus.rd_valid != 4'b0000) begin
            if (exp_q.size() == 0) check("rd_extra", 1, 0);
            else check("rd_data", bus.rd_data, exp_q.pop_front());
         end
         worst = 0;
         for (int k = 0; k < 4; k++) begin
            if (!s_req[k]) wt[k] = 0;
            else if (!s_frz) begin
               if (bus.gnt[k]) wt[k] = 0;
               else wt[k]++;
            end
            if (wt[k] > worst) worst = wt[k];
         end
         check("starve_le3", worst <= 3, 1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   // ---------------- directed + random sequence ----------------
   logic [3:0]    exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [AW-1:0] exp_a [4] = '{17'h000, 17'h100, 17'h200, 17'h300};
   int dens;

   initial begin
      rst_n = 1'b0;
      r_in  = 4'b0000;
      frz   = 1'b0;
      for (int k = 0; k < 4; k++) a_in[k] = '0;
      #3;
      check("rst_gnt", bus.gnt, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_rom_addr", bus.rom_addr, 0);
      check("rst_ptr", bus.ptr, 0);
      check("rst_busy", bus.busy, 0);

      // All four requesting from reset: strict rotation.
      r_in = 4'b1111;
      for (int k = 0; k < 4; k++) a_in[k] = AW'(k * 32'h100);
      look();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         look();
         check("rot_gnt", bus.gnt, exp_g[i]);
         if (i < 4) check("rot_addr", bus.rom_addr, exp_a[i]);
         check("rot_rdv", bus.rd_valid, (i == 0) ? 4'b0000 : exp_g[i-1]);
      end

      // Sole requester 1 gets back-to-back grants with a fresh address each time.
      tick();
      r_in    = 4'b0010;
      a_in[1] = 17'h1000;
      for (int i = 0; i < 8; i++) begin
         tick();
         a_in[1] = AW'(32'h1001 + i);
         look();
         check("solo_gnt", bus.gnt, 4'b0010);
         check("solo_addr", bus.rom_addr, AW'(32'h1000 + i));
      end
      tick();
      r_in = 4'b0000;

      // p=1 with req 1001: requester 3 first, then 0, pointer ends at 1.
      r_in    = 4'b0001;
      a_in[0] = 17'h00aa;
      tick();
      r_in    = 4'b1001;
      a_in[0] = 17'h00cc;
      a_in[3] = 17'h03bb;
      look();
      check("p1_gnt0", bus.gnt, 4'b0001);
      tick();
      r_in = 4'b0001;
      look();
      check("p1_gnt3", bus.gnt, 4'b1000);
      check("p1_addr3", bus.rom_addr, 17'h03bb);
      tick();
      r_in = 4'b0000;
      look();
      check("p1_gnt0b", bus.gnt, 4'b0001);
      check("p1_addr0", bus.rom_addr, 17'h00cc);
      check("p1_ptr", bus.ptr, 2'd1);

      // Grant 2, then freeze for five cycles with everyone requesting.
      tick();
      r_in    = 4'b0100;
      a_in[2] = 17'h02dd;
      tick();
      frz  = 1'b1;
      r_in = 4'b1111;
      for (int k = 0; k < 4; k++) a_in[k] = AW'(k * 32'h100);
      look();
      check("frz_gnt2", bus.gnt, 4'b0100);
      check("frz_addr2", bus.rom_addr, 17'h02dd);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 4) frz = 1'b0;
         look();
         check("frz_gnt0", bus.gnt, 4'b0000);
         check("frz_hold", bus.rom_addr, 17'h02dd);
         check("frz_rdv", bus.rd_valid, (i == 0) ? 4'b0100 : 4'b0000);
      end
      tick();
      look();
      check("unfrz_gnt3", bus.gnt, 4'b1000);
      check("unfrz_addr", bus.rom_addr, 17'h300);

      // Reset pulse in the middle of a grant-1 cycle.
      tick();
      r_in = 4'b0010;
      tick();
      r_in = 4'b1111;
      look();
      check("mrst_pre_gnt", bus.gnt, 4'b0010);
      #1 rst_n = 1'b0;
      #1;
      check("mrst_gnt", bus.gnt, 0);
      check("mrst_rdv", bus.rd_valid, 0);
      check("mrst_addr", bus.rom_addr, 0);
      check("mrst_ptr", bus.ptr, 0);
      #2 rst_n = 1'b1;
      tick();
      r_in = 4'b0000;
      look();
      check("mrst_first_gnt", bus.gnt, 4'b0001);
      check("mrst_no_rdv", bus.rd_valid, 4'b0000);

      // Random traffic with held requests, occasional drops and freeze.
      dens = 50;
      for (int c = 0; c < 10000; c++) begin
         tick();
         for (int k = 0; k < 4; k++) begin
            if (!(r_in[k] && !bus.gnt[k] && ($urandom_range(0, 7) != 0))) begin
               r_in[k] = ($urandom_range(0, 99) < dens);
               a_in[k] = AW'($urandom_range(0, 131071));
            end
         end
         frz = ($urandom_range(0, 9) == 0);
         if (c % 500 == 0) dens = $urandom_range(5, 95);
      end

      tick();
      r_in = 4'b0000;
      frz  = 1'b0;
      repeat (4) tick();
      look();
      check("q_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_rom_arb.md
SPRITE_ROM_ARB -- requirements
Module: sprite_rom_arb

Interface
REQ-001 Parameter AW, default 17, sprite ROM address width.
REQ-002 Parameter DW, default 12, ROM pixel data width (4-bit R/G/B).
REQ-003 Parameter NREQ is fixed at 4 requesters (0 player, 1 player bullet, 2 enemy, 3 enemy bullet) and SHALL NOT be parameterised.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req  input  4  per-requester access request, level.
REQ-007 addr0..addr3  input  AW each  per-requester ROM address, valid while matching req bit high.
REQ-008 freeze  input  1  when high, no new grants are issued.
REQ-009 gnt  output  4  one-hot grant, registered, one-cycle pulse per access.
REQ-010 rom_addr  output  AW  registered address to the synchronous-read sprite ROM.
REQ-011 rom_data  input  DW  ROM read data, valid one cycle after rom_addr is sampled.
REQ-012 rd_valid  output  4  one-hot, marks rd_data as belonging to that requester.
REQ-013 rd_data  output  DW  combinational pass-through of rom_data.
REQ-014 busy  output  1  high when any req bit is high or any rd_valid bit is high.

Function
REQ-015 Arbitration SHALL be round-robin with a 2-bit priority pointer p; search order p, p+1, p+2, p+3 mod 4; first requester with req high wins.
REQ-016 On the edge ending cycle N, if a winner k exists and freeze=0: gnt <= onehot(k), rom_addr <= addr_k, p <= (k+1) mod 4.
REQ-017 If no req bit is high or freeze=1: gnt <= 0, rom_addr holds its value, p holds.
REQ-018 At most one gnt bit SHALL be high in any cycle.
REQ-019 rd_valid SHALL be gnt delayed one cycle (rd_valid[k] high in cycle N+2 for a grant decided in cycle N); rd_data = rom_data with no register.
REQ-020 A requester SHALL keep req and its address stable until it sees its gnt bit; it may drop req, or keep req high with a new address, in the gnt cycle.
REQ-021 A sole active requester SHALL be granted every cycle (back-to-back, one access per clock).
REQ-022 With all four requesting continuously, grants SHALL rotate 0,1,2,3,0,... from reset; worst-case wait is 3 cycles from the first cycle req is seen.
REQ-023 A req bit that falls before its grant SHALL be ignored (no grant, no rd_valid).
REQ-024 Asserting freeze SHALL NOT cancel an in-flight access: rd_valid for a grant issued before freeze rose still appears.
REQ-025 Deasserting freeze SHALL resume arbitration from the held pointer on the next edge.
REQ-026 Address values SHALL pass unmodified; no arithmetic on addresses.

Reset
REQ-027 While rst_n=0, immediately and independent of clk: gnt=0, rd_valid=0, rom_addr=0, p=0.
REQ-028 Reset mid-access SHALL discard the in-flight access; no rd_valid is produced for it after release.
REQ-029 The first edge after rst_n rises SHALL arbitrate normally with requester 0 at highest priority.

Verification
REQ-030 Reset, req=4'b1111, addrN=N*0x100 -> gnt 0001,0010,0100,1000,0001 on successive cycles; rom_addr 0x000,0x100,0x200,0x300; rd_valid follows gnt by one cycle.
REQ-031 Only req[1] high, addr1 incremented 0x1000..0x1007 each gnt cycle -> 8 consecutive gnt=0010, rom_addr 0x1000..0x1007, rd_data matches ROM model.
REQ-032 req=4'b1001 with p=1 -> gnt 1000 then 0001; then p=1.
REQ-033 Grant to requester 2, freeze=1 next cycle with req=4'b1111 for 5 cycles -> rd_valid=0100 once, gnt=0 for 5 cycles, rom_addr held; freeze=0 -> gnt=1000 next cycle.
REQ-034 rst_n pulsed low for 3 ns between clock edges during gnt=0010 -> gnt, rd_valid, rom_addr cleared immediately; no rd_valid=0010 after release; first grant goes to lowest-index requester.
REQ-035 Random req/addr/freeze for 10,000 cycles against a reference model -> gnt one-hot or zero, no starvation beyond 3 cycles while freeze=0, every grant followed by exactly one rd_valid.
